// File: rtl/seg7_scan2_pkg.sv
// Shared definitions for the two-digit 7-segment scan driver:
// digit patterns ({g,f,e,d,c,b,a}) and the scan FSM state encoding.
package seg7_scan2_pkg;

    typedef enum logic [1:0] {
        S_BLANK0 = 2'd0,
        S_ON0    = 2'd1,
        S_BLANK1 = 2'd2,
        S_ON1    = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    // Non-BCD codes show a lone "-".
    localparam logic [6:0] SEG_BAD = 7'h40;

endpackage

// File: rtl/seg7_dec.sv
// Combinational 4-bit digit to 7-segment pattern decoder,
// reusable by any display block.
module seg7_dec
    import seg7_scan2_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BAD;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BAD;
        endcase
    end

endmodule

// File: rtl/seg7_scan2.sv
// Two-digit multiplexed 7-segment driver with blanking gaps and
// once-per-frame capture of the packed BCD input.
module seg7_scan2
    import seg7_scan2_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16,
    parameter int LZB       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bcd_in,
    output logic [6:0] seg_out,
    output logic [1:0] dig_sel
);

    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);
    localparam logic [15:0] SLOT_LAST  = 16'(SCAN_DIV - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [7:0]  disp_reg;
    logic        capture;
    logic [3:0]  digit;
    logic [6:0]  dec_seg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_BLANK0;
            cnt      <= 16'd0;
            disp_reg <= 8'h00;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (capture)
                disp_reg <= bcd_in;
        end
    end

    // cnt runs through the blank part into the lit part of a slot
    // and only clears when the slot ends.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 16'd1;
        capture = 1'b0;
        case (state)
            S_BLANK0: if (cnt == BLANK_LAST) state_n = S_ON0;
            S_BLANK1: if (cnt == BLANK_LAST) state_n = S_ON1;
            S_ON0: begin
                if (cnt == SLOT_LAST) begin
                    state_n = S_BLANK1;
                    cnt_n   = 16'd0;
                end
            end
            S_ON1: begin
                if (cnt == SLOT_LAST) begin
                    state_n = S_BLANK0;
                    cnt_n   = 16'd0;
                    capture = 1'b1;
                end
            end
            default: state_n = S_BLANK0;
        endcase
    end

    assign digit = (state == S_ON1) ? disp_reg[7:4] : disp_reg[3:0];

    seg7_dec u_dec (
        .digit (digit),
        .seg   (dec_seg)
    );

    always_comb begin
        dig_sel = 2'b00;
        seg_out = 7'h00;
        case (state)
            S_ON0: begin
                dig_sel = 2'b01;
                seg_out = dec_seg;
            end
            S_ON1: begin
                dig_sel = 2'b10;
                if (!((LZB != 0) && (disp_reg[7:4] == 4'd0)))
                    seg_out = dec_seg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seg7_scan2.sv
// Directed bench for seg7_scan2 with SCAN_DIV=4, BLANK_CYC=1;
// one instance with leading-zero blanking and one without.
module tb_seg7_scan2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] bcd_in = 8'h00;
    logic [6:0] seg_out, seg_out0;
    logic [1:0] dig_sel, dig_sel0;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  mon = 1'b0;

    always #5 clk = ~clk;

    seg7_scan2 #(.SCAN_DIV(4), .BLANK_CYC(1), .LZB(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .bcd_in  (bcd_in),
        .seg_out (seg_out),
        .dig_sel (dig_sel)
    );

    seg7_scan2 #(.SCAN_DIV(4), .BLANK_CYC(1), .LZB(0)) dut0 (
        .clk     (clk),
        .reset   (reset),
        .bcd_in  (bcd_in),
        .seg_out (seg_out0),
        .dig_sel (dig_sel0)
    );

    typedef struct {
        string      name;
        logic [7:0] bcd;
        logic [6:0] ones;
        logic [6:0] tens;
        logic [6:0] tens0;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(string name, logic [8:0] got, logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon) begin
            n_cmp++;
            if (dig_sel === 2'b11 || dig_sel0 === 2'b11) begin
                n_bad++;
                $display("FAIL onehot: got %b/%b expected not 11",
                         dig_sel, dig_sel0);
            end
        end
    end

    // Enter at a negedge where the DUT is in cycle 0 of a frame.
    task automatic frame(string name, logic [6:0] ones, logic [6:0] tens,
                         logic [6:0] tens0, int chg_at, logic [7:0] chg_val);
        for (int i = 0; i < 8; i++) begin
            logic [1:0] ed;
            logic [6:0] es, es0;
            if (i == 0 || i == 4) begin
                ed = 2'b00; es = 7'h00; es0 = 7'h00;
            end else if (i < 4) begin
                ed = 2'b01; es = ones; es0 = ones;
            end else begin
                ed = 2'b10; es = tens; es0 = tens0;
            end
            chk($sformatf("%s[%0d]", name, i), {dig_sel, seg_out}, {ed, es});
            chk($sformatf("%s_lzb0[%0d]", name, i),
                {dig_sel0, seg_out0}, {ed, es0});
            if (i == chg_at) bcd_in = chg_val;
            @(negedge clk);
        end
    endtask

    task automatic do_reset(logic [7:0] v);
        reset  = 1'b1;
        bcd_in = v;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"v47", 8'h47, 7'h07, 7'h66, 7'h66};
        vecs[1] = '{"v05", 8'h05, 7'h6D, 7'h00, 7'h3F};
        vecs[2] = '{"vA3", 8'hA3, 7'h4F, 7'h40, 7'h40};
        vecs[3] = '{"v00", 8'h00, 7'h3F, 7'h00, 7'h3F};
        vecs[4] = '{"v99", 8'h99, 7'h6F, 7'h6F, 7'h6F};
        vecs[5] = '{"v1F", 8'h1F, 7'h40, 7'h06, 7'h06};
        vecs[6] = '{"v80", 8'h80, 7'h3F, 7'h7F, 7'h7F};

        @(negedge clk);
        @(negedge clk);
        mon = 1'b1;

        for (int k = 0; k < 7; k++) begin
            do_reset(vecs[k].bcd);
            frame({vecs[k].name, "_f1"}, 7'h3F, 7'h00, 7'h3F, -1, 8'h00);
            frame({vecs[k].name, "_f2"}, vecs[k].ones, vecs[k].tens,
                  vecs[k].tens0, -1, 8'h00);
            frame({vecs[k].name, "_f3"}, vecs[k].ones, vecs[k].tens,
                  vecs[k].tens0, -1, 8'h00);
        end

        // Input change during ON0 must not reach the current frame.
        do_reset(8'h47);
        frame("mid_f1", 7'h3F, 7'h00, 7'h3F, -1, 8'h00);
        frame("mid_f2", 7'h07, 7'h66, 7'h66, 2, 8'h52);
        frame("mid_f3", 7'h5B, 7'h6D, 7'h6D, -1, 8'h00);

        // Reset during ON1 with 47 on display.
        do_reset(8'h47);
        frame("rst_f1", 7'h3F, 7'h00, 7'h3F, -1, 8'h00);
        frame("rst_f2", 7'h07, 7'h66, 7'h66, -1, 8'h00);
        repeat (5) @(negedge clk);
        chk("rst_on1", {dig_sel, seg_out}, {2'b10, 7'h66});
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_out", {dig_sel, seg_out}, 9'h000);
        chk("rst_disp", {1'b0, dut.disp_reg}, 9'h000);
        frame("rst_f3", 7'h3F, 7'h00, 7'h3F, -1, 8'h00);

        // Reset held over the capture edge beats the capture.
        do_reset(8'h00);
        frame("cap_f1", 7'h3F, 7'h00, 7'h3F, -1, 8'h00);
        bcd_in = 8'h99;
        repeat (7) @(negedge clk);
        chk("cap_on1", {dig_sel, seg_out}, {2'b10, 7'h00});
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("cap_disp", {1'b0, dut.disp_reg}, 9'h000);
        frame("cap_f2", 7'h3F, 7'h00, 7'h3F, -1, 8'h00);
        frame("cap_f3", 7'h6F, 7'h6F, 7'h6F, -1, 8'h00);

        mon = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
